// File: rtl/mod_mult_sched.sv
// Round-robin scheduler sharing one pipelined Barrett modular multiplier between N_REQ requesters.
// Optional statistics counters are enabled with `define MOD_MULT_SCHED_STATS_EN.

module mod_mult (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic [63:0] q,
  output logic [63:0] r
);
  // Barrett constant is fixed for q = 1073750017; mu = floor(2^62 / q)
  localparam logic [127:0] Q_REF = 128'd1073750017;
  localparam logic [63:0]  MU    = 64'((128'd1 << 62) / Q_REF);

  logic [63:0]  x;
  logic [127:0] xm;
  logic [63:0]  qh, r0, r1;

  // a,b < q < 2^31, so the 64-bit product is exact
  assign x  = a * b;
  assign xm = {64'b0, x} * {64'b0, MU};
  assign qh = 64'(xm >> 62);
  // quotient estimate is low by at most 2, so two conditional subtracts finish the reduction
  assign r0 = x - qh * q;
  assign r1 = (r0 >= q) ? r0 - q : r0;
  assign r  = (r1 >= q) ? r1 - q : r1;
endmodule

module mod_mult_sched #(
  parameter int N_REQ       = 4,
  parameter int PIPE_STAGES = 3,
  parameter int ID_W        = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [63:0]           q,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [N_REQ*64-1:0]   req_a,
  input  logic [N_REQ*64-1:0]   req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [63:0]           rsp_data,
  output logic                  busy
`ifdef MOD_MULT_SCHED_STATS_EN
  ,
  output logic [N_REQ*32-1:0]   grant_cnt,
  output logic [31:0]           stall_cnt
`endif
);
  localparam int STAGES = PIPE_STAGES - 1;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [63:0]     data;
  } ent_t;

  logic [STAGES:0]            vld_pipe;
  ent_t [STAGES:0]            ent_pipe;
  logic [ID_W-1:0]            ptr;
  logic [ID_W-1:0]            gnt_idx;
  logic [ID_W-1:0]            j;
  logic                       found;
  logic                       grant;
  logic                       adv;
  logic [N_REQ-1:0][63:0]     a_lane, b_lane;
  logic [63:0]                mm_out;

  assign a_lane = req_a;
  assign b_lane = req_b;

  assign rsp_valid = vld_pipe[STAGES];
  assign rsp_id    = ent_pipe[STAGES].id;
  assign rsp_data  = ent_pipe[STAGES].data;
  assign busy      = |vld_pipe;
  assign adv       = !rsp_valid || rsp_ready;

  // first valid requester after ptr, wrapping modulo N_REQ
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    j       = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      j = ID_W'((int'(ptr) + k) % N_REQ);
      if (!found && req_valid[j]) begin
        found   = 1'b1;
        gnt_idx = j;
      end
    end
  end

  assign grant     = found && adv && !rst;
  assign req_ready = grant ? (N_REQ'(1) << gnt_idx) : '0;

  mod_mult u_mm (
    .a (a_lane[gnt_idx]),
    .b (b_lane[gnt_idx]),
    .q (q),
    .r (mm_out)
  );

  // global stall: every stage shifts together only when the head can move
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      ent_pipe <= '0;
      ptr      <= ID_W'(N_REQ - 1);
    end else if (adv) begin
      vld_pipe[0] <= grant;
      ent_pipe[0] <= ent_t'{id: gnt_idx, data: mm_out};
      for (int s = 1; s <= STAGES; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        ent_pipe[s] <= ent_pipe[s-1];
      end
      if (grant) ptr <= gnt_idx;
    end
  end

`ifdef MOD_MULT_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++)
        if (req_valid[i] && req_ready[i]) grant_cnt[32*i +: 32] <= grant_cnt[32*i +: 32] + 32'd1;
      if (rsp_valid && !rsp_ready) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif
endmodule
